// File: rtl/btn_cmd_decoder_if.sv
// Button/command bundle for btn_cmd_decoder: raw buttons in, animation commands out.
// slave = decoder side, master = the block driving buttons and consuming commands.
interface btn_cmd_decoder_if;
  logic       btn_rst;
  logic       btn_en;
  logic       btn_spd;
  logic       en;
  logic       rst_pulse;
  logic [1:0] speed_sel;
  logic       state_dbg;

  modport master (
    output btn_rst, btn_en, btn_spd,
    input  en, rst_pulse, speed_sel, state_dbg
  );

  modport slave (
    input  btn_rst, btn_en, btn_spd,
    output en, rst_pulse, speed_sel, state_dbg
  );
endinterface

// File: rtl/btn_cmd_decoder.sv
// Debounces three push-buttons and turns them into LED-animation commands (enable, reset, speed).
// Optional macro LONG_PRESS_EN: btn_en toggles on short release; a long hold issues reset+pause.
module btn_cmd_decoder #(
  parameter int DIV_BITS   = 16,
  parameter int DB_LEN     = 4,
  parameter int LONG_TICKS = 64
) (
  input  logic             clk,
  input  logic             rst,
  btn_cmd_decoder_if.slave bus
);

  typedef enum logic {PAUSED = 1'b0, RUNNING = 1'b1} state_e;

  localparam int BTN_RST = 0;
  localparam int BTN_EN  = 1;
  localparam int BTN_SPD = 2;

  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  assign raw = {bus.btn_spd, bus.btn_en, bus.btn_rst};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  logic [DIV_BITS-1:0] div_q;
  logic                tick;
  assign tick = &div_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_q + DIV_BITS'(1);
  end

  // Level changes only once the whole sample window agrees; mixed windows hold.
  logic [DB_LEN-1:0] sr_q [3];
  logic [2:0]        db_q, db_d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) sr_q[b] <= '0;
      db_q   <= '0;
      db_d_q <= '0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (tick) sr_q[b] <= {sr_q[b][DB_LEN-2:0], sync2_q[b]};
        if (&sr_q[b])       db_q[b] <= 1'b1;
        else if (~|sr_q[b]) db_q[b] <= 1'b0;
      end
      db_d_q <= db_q;
    end
  end

  logic rst_evt, spd_evt, en_evt, long_evt;
  assign rst_evt = db_q[BTN_RST] & ~db_d_q[BTN_RST];
  assign spd_evt = db_q[BTN_SPD] & ~db_d_q[BTN_SPD];

`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  logic [HW-1:0] hold_q;

  // hold_q survives the release cycle so the release can still see the hold length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (db_q[BTN_EN]) begin
      if (tick && (hold_q < HW'(LONG_TICKS))) hold_q <= hold_q + HW'(1);
    end else if (!db_d_q[BTN_EN]) begin
      hold_q <= '0;
    end
  end

  assign long_evt = tick && db_q[BTN_EN] && (hold_q == HW'(LONG_TICKS - 1));
  assign en_evt   = ~db_q[BTN_EN] && db_d_q[BTN_EN] && (hold_q < HW'(LONG_TICKS));
`else
  assign long_evt = 1'b0;
  assign en_evt   = db_q[BTN_EN] & ~db_d_q[BTN_EN];
`endif

  state_e     state_q, state_d;
  logic [1:0] speed_q, speed_d;
  logic       pulse_q, pulse_d;
  logic       en_q;

  // Later assignments win: rst event beats long press beats toggle.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    pulse_d = 1'b0;
    if (en_evt)  state_d = (state_q == PAUSED) ? RUNNING : PAUSED;
    if (spd_evt) speed_d = (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
    if (long_evt) begin
      pulse_d = 1'b1;
      state_d = PAUSED;
    end
    if (rst_evt) begin
      pulse_d = 1'b1;
      state_d = PAUSED;
      speed_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PAUSED;
      speed_q <= 2'd0;
      pulse_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      pulse_q <= pulse_d;
      en_q    <= (state_d == RUNNING);
    end
  end

  assign bus.en        = en_q;
  assign bus.rst_pulse = pulse_q;
  assign bus.speed_sel = speed_q;
  assign bus.state_dbg = (state_q == RUNNING);

endmodule

// File: tb/tb_btn_cmd_decoder.sv
// Bench for btn_cmd_decoder: directed scenarios plus random button actions scored
// against a press-level model (one command per completed press, none per glitch).
`timescale 1ns/1ps
module tb_btn_cmd_decoder;
  localparam int DIV_BITS   = 2;
  localparam int DB_LEN     = 4;
  localparam int LONG_TICKS = 8;
  localparam int TICK       = 1 << DIV_BITS;
  localparam int SETTLE     = (DB_LEN + 4) * TICK;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_cmd_decoder_if bus ();

  btn_cmd_decoder #(
    .DIV_BITS  (DIV_BITS),
    .DB_LEN    (DB_LEN),
    .LONG_TICKS(LONG_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: expected {en, speed_sel} after each action
  logic [2:0] exp_q[$];
  logic       m_en     = 1'b0;
  logic [1:0] m_spd    = 2'd0;
  int         m_pulses = 0;

  // rst_pulse monitor
  int   pulse_cnt  = 0;
  int   pulse_wide = 0;
  logic pulse_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pulse_prev = 1'b0;
    end else begin
      if (bus.rst_pulse) pulse_cnt++;
      if (bus.rst_pulse && pulse_prev) pulse_wide++;
      pulse_prev = bus.rst_pulse;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks (inputs change 1ns after posedge)
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0:       bus.btn_rst = v;
      1:       bus.btn_en  = v;
      default: bus.btn_spd = v;
    endcase
  endtask

  task automatic model_apply(input int idx);
    case (idx)
      0: begin m_pulses++; m_en = 1'b0; m_spd = 2'd0; end
      1: m_en = ~m_en;
      default: m_spd = (m_spd == 2'd2) ? 2'd0 : m_spd + 2'd1;
    endcase
    exp_q.push_back({m_en, m_spd});
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, ".en"}, 32'(bus.en), 32'(e[2]));
      check_eq({tag, ".speed"}, 32'(bus.speed_sel), 32'(e[1:0]));
      check_eq({tag, ".pulses"}, 32'(pulse_cnt), 32'(m_pulses));
    end
  endtask

  task automatic do_press(input int idx, input int hold, input string tag);
    set_btn(idx, 1'b1);
    wait_cyc(hold);
    set_btn(idx, 1'b0);
    wait_cyc(SETTLE);
    model_apply(idx);
    check_outputs(tag);
  endtask

  task automatic do_glitch(input int idx, input int width, input string tag);
    set_btn(idx, 1'b1);
    wait_cyc(width);
    set_btn(idx, 1'b0);
    wait_cyc(SETTLE);
    exp_q.push_back({m_en, m_spd});
    check_outputs(tag);
  endtask

  initial begin
    int waited;
    int hold;
    bus.btn_rst = 1'b0;
    bus.btn_en  = 1'b0;
    bus.btn_spd = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.en", 32'(bus.en), 32'd0);
    check_eq("reset.pulse", 32'(bus.rst_pulse), 32'd0);
    check_eq("reset.speed", 32'(bus.speed_sel), 32'd0);
    rst = 1'b0;

    // idle for 200 cycles
    for (int i = 0; i < 200; i++) begin
      wait_cyc(1);
      check_eq("idle", 32'({bus.en, bus.rst_pulse, bus.speed_sel}), 32'd0);
    end

    // bounce 1,0,1,0 one tick per level
    for (int i = 0; i < 4; i++) begin
      bus.btn_en = ~i[0];
      wait_cyc(TICK);
    end
    bus.btn_en = 1'b0;
    wait_cyc(SETTLE);
    exp_q.push_back({m_en, m_spd});
    check_outputs("bounce");

    // btn_en held: exactly one toggle
`ifdef LONG_PRESS_EN
    hold = 22;
    bus.btn_en = 1'b1;
    wait_cyc(hold);
    check_eq("en_before_release", 32'(bus.en), 32'd0);
`else
    hold = 40;
    bus.btn_en = 1'b1;
    waited = 0;
    while (waited < 24 && bus.en !== 1'b1) begin
      wait_cyc(1);
      waited++;
    end
    check_eq("en_rise", 32'(bus.en), 32'd1);
    check_eq("en_latency_le_20", 32'(waited <= 20), 32'd1);
    wait_cyc(hold - waited);
`endif
    bus.btn_en = 1'b0;
    wait_cyc(SETTLE);
    model_apply(1);
    check_outputs("en_hold");

    // speed stepping 1,2,0 then up to 2
    do_press(2, 22, "spd1");
    do_press(2, 22, "spd2");
    do_press(2, 22, "spd0");
    do_press(2, 22, "spd_a");
    do_press(2, 22, "spd_b");

    // btn_rst and btn_en pressed together
    bus.btn_rst = 1'b1;
    bus.btn_en  = 1'b1;
    wait_cyc(22);
    bus.btn_rst = 1'b0;
    bus.btn_en  = 1'b0;
    wait_cyc(SETTLE);
    m_pulses++;
    m_spd = 2'd0;
`ifdef LONG_PRESS_EN
    m_en = ~1'b0;
`else
    m_en = 1'b0;
`endif
    exp_q.push_back({m_en, m_spd});
    check_outputs("rst_and_en");

    // random actions
    for (int i = 0; i < 30; i++) begin
      int idx;
      idx = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) do_glitch(idx, $urandom_range(1, 8), "rand_glitch");
      else                           do_press(idx, $urandom_range(20, 24), "rand_press");
    end

    // async reset mid-hold
    if (m_en == 1'b0) do_press(1, 22, "pre_arst_en");
    if (m_spd == 2'd0) do_press(2, 22, "pre_arst_spd");
    bus.btn_en = 1'b1;
    wait_cyc(10);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.en", 32'(bus.en), 32'd0);
    check_eq("arst.pulse", 32'(bus.rst_pulse), 32'd0);
    check_eq("arst.speed", 32'(bus.speed_sel), 32'd0);
    check_eq("arst.state", 32'(bus.state_dbg), 32'd0);
    m_en  = 1'b0;
    m_spd = 2'd0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(22);
    bus.btn_en = 1'b0;
    wait_cyc(SETTLE);
    model_apply(1);
    check_outputs("after_arst");

`ifdef LONG_PRESS_EN
    // long hold: reset pulse and pause, no toggle on release
    bus.btn_en = 1'b1;
    wait_cyc(60);
    m_pulses++;
    m_en = 1'b0;
    check_eq("long.en", 32'(bus.en), 32'd0);
    check_eq("long.pulses", 32'(pulse_cnt), 32'(m_pulses));
    bus.btn_en = 1'b0;
    wait_cyc(SETTLE);
    exp_q.push_back({m_en, m_spd});
    check_outputs("long_release");
`endif

    check_eq("pulse_width", 32'(pulse_wide), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
